// File: rtl/jk_bank_sequencer_pkg.sv
// jk_seq_pkg: op/state encodings and the JK next-state equation
package jk_seq_pkg;
    typedef logic [1:0] op_t;
    localparam op_t OP_SET = 2'b00, OP_CLR = 2'b01, OP_TGL = 2'b10, OP_CNT = 2'b11;
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10;
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction
endpackage

// File: rtl/jk_bank_sequencer_if.sv
// jk_bank_sequencer_if: command handshake plus bank state/status
interface jk_bank_sequencer_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
    import jk_seq_pkg::*;
    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_reps;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    modport master (output cmd_valid, cmd_op, cmd_mask, cmd_reps, input cmd_ready, q, busy, done);
    modport slave  (input cmd_valid, cmd_op, cmd_mask, cmd_reps, output cmd_ready, q, busy, done);
endinterface

// File: rtl/jk_bank_sequencer_cell.sv
// jk_cell: single JK flip-flop, sync active-high reset clears q
module jk_cell import jk_seq_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk) q <= rst ? 1'b0 : jk_next(j, k, q);
endmodule

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: runs SET/CLR/TOGGLE/COUNT commands on a JK bank for a set number of edges
module jk_bank_sequencer import jk_seq_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    jk_bank_sequencer_if.slave bus
);
    logic [1:0]       state;
    op_t              op;
    logic [WIDTH-1:0] mask, q, j, k, t;
    logic [CNT_W-1:0] rem;
    logic             c, run;
    assign run = state == S_RUN;
    assign bus.cmd_ready = ~rst & (state == S_IDLE);
    assign bus.busy = state != S_IDLE;
    assign bus.done = state == S_DONE;
    assign bus.q = q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op <= OP_SET;
            mask <= '0;
            rem <= '0;
        end else if (state == S_IDLE) begin
            if (bus.cmd_valid) begin
                op <= bus.cmd_op;
                mask <= bus.cmd_mask;
                rem <= bus.cmd_reps;
                state <= (bus.cmd_reps == '0) ? S_DONE : S_RUN;
            end
        end else if (run) begin
            rem <= rem - 1'b1;
            if (rem == CNT_W'(1)) state <= S_DONE;
        end else begin
            state <= S_IDLE;
        end
    end
    // t[i] is the ripple-carry toggle enable: all lower bits set
    always_comb begin
        t = '0;
        c = 1'b1;
        for (int b = 0; b < WIDTH; b++) begin
            t[b] = c;
            c = c & q[b];
        end
    end
    always_comb begin
        j = !run ? '0 : (op == OP_SET || op == OP_TGL) ? mask : (op == OP_CNT) ? t : '0;
        k = !run ? '0 : (op == OP_CLR || op == OP_TGL) ? mask : (op == OP_CNT) ? t : '0;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (.clk(clk), .rst(rst), .j(j[i]), .k(k[i]), .q(q[i]));
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: table-driven commands checked cycle by cycle against a scoreboard
module tb_jk_bank_sequencer;
    import jk_seq_pkg::*;
    localparam int W = 8;
    localparam int C = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    jk_bank_sequencer_if #(.WIDTH(W), .CNT_W(C)) bus ();
    jk_bank_sequencer #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         ready;
        string        tag;
    } exp_t;
    typedef struct {
        op_t          op;
        logic [W-1:0] mask;
        logic [C-1:0] reps;
        logic [W-1:0] qend;
    } vec_t;
    exp_t sb[$];
    vec_t tbl[9];
    int checks = 0;
    int failures = 0;
    logic [W-1:0] mq = '0;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [W+2:0] act, input logic [W+2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s {q,busy,done,ready} act=%h exp=%h", tag, act, exp);
        end
    endtask
    task automatic push(input logic [W-1:0] q, input logic b, input logic d, input logic r, input string tag);
        exp_t e;
        e.q = q; e.busy = b; e.done = d; e.ready = r; e.tag = tag;
        sb.push_back(e);
    endtask
    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        chk(e.tag, {bus.q, bus.busy, bus.done, bus.cmd_ready}, {e.q, e.busy, e.done, e.ready});
    endtask
    function automatic logic [W-1:0] step(input op_t op, input logic [W-1:0] m, input logic [W-1:0] q);
        return op == OP_SET ? (q | m) : op == OP_CLR ? (q & ~m) : op == OP_TGL ? (q ^ m) : q + 1'b1;
    endfunction
    task automatic issue(input op_t op, input logic [W-1:0] m, input logic [C-1:0] reps, input string tag,
                         input bit hold, input op_t nop, input logic [W-1:0] nm, input logic [C-1:0] nreps);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_mask = m;
        bus.cmd_reps = reps;
        tick();
        bus.cmd_valid = hold;
        bus.cmd_op = hold ? nop : op + 2'd1;
        bus.cmd_mask = hold ? nm : ~m;
        bus.cmd_reps = hold ? nreps : C'($urandom);
        push(mq, 1'b1, reps == '0, 1'b0, $sformatf("%s_k0", tag));
        for (int s = 1; s <= int'(reps); s++) begin
            mq = step(op, m, mq);
            push(mq, 1'b1, s == int'(reps), 1'b0, $sformatf("%s_k%0d", tag, s));
        end
        push(mq, 1'b0, 1'b0, 1'b1, $sformatf("%s_idle", tag));
        pop_check();
        while (sb.size() != 0) begin
            tick();
            pop_check();
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end
    initial begin
        tbl[0] = '{OP_SET, 8'hA5, 8'd1, 8'hA5};
        tbl[1] = '{OP_TGL, 8'h0F, 8'd3, 8'hAA};
        tbl[2] = '{OP_SET, 8'hFE, 8'd1, 8'hFE};
        tbl[3] = '{OP_CNT, 8'h00, 8'd5, 8'h03};
        tbl[4] = '{OP_CLR, 8'hFF, 8'd0, 8'h03};
        tbl[5] = '{OP_TGL, 8'h3C, 8'd2, 8'h03};
        tbl[6] = '{OP_SET, 8'h81, 8'd2, 8'h83};
        tbl[7] = '{OP_CLR, 8'hF0, 8'd4, 8'h03};
        tbl[8] = '{OP_CNT, 8'h00, 8'd3, 8'h06};
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_SET;
        bus.cmd_mask = 8'hFF;
        bus.cmd_reps = 8'd1;
        tick();
        chk("rst_cyc1", {bus.q, bus.busy, bus.done, bus.cmd_ready}, {8'h00, 3'b000});
        tick();
        chk("rst_cyc2", {bus.q, bus.busy, bus.done, bus.cmd_ready}, {8'h00, 3'b000});
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_release", {bus.q, bus.busy, bus.done, bus.cmd_ready}, {8'h00, 3'b001});
        for (int n = 0; n < 9; n++) begin
            issue(tbl[n].op, tbl[n].mask, tbl[n].reps, $sformatf("vec%0d", n), 1'b0, OP_SET, '0, '0);
            chk($sformatf("vec%0d_qend", n), {bus.q, 3'b001}, {tbl[n].qend, 3'b001});
        end
        issue(OP_SET, 8'h70, 8'd3, "hold_a", 1'b1, OP_TGL, 8'hFF, 8'd1);
        issue(OP_TGL, 8'hFF, 8'd1, "hold_b", 1'b0, OP_SET, '0, '0);
        chk("hold_qend", {bus.q, 3'b001}, {8'h89, 3'b001});
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_CNT;
        bus.cmd_mask = 8'h00;
        bus.cmd_reps = 8'd10;
        tick();
        bus.cmd_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                tick();
                mq = mq + 1'b1;
            end
            chk($sformatf("abort_k%0d", s), {bus.q, bus.busy, bus.done, bus.cmd_ready}, {mq, 3'b100});
        end
        rst = 1'b1;
        tick();
        mq = '0;
        chk("abort_rst", {bus.q, bus.busy, bus.done, bus.cmd_ready}, {8'h00, 3'b000});
        rst = 1'b0;
        #1;
        chk("abort_ready", {bus.q, bus.busy, bus.done, bus.cmd_ready}, {8'h00, 3'b001});
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("abort_quiet%0d", s), {bus.q, bus.busy, bus.done, bus.cmd_ready}, {8'h00, 3'b001});
        end
        issue(OP_CNT, 8'hFF, 8'd2, "post_abort", 1'b0, OP_SET, '0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
